// File: rtl/machine_pkg.sv
// Shared types and coin values for the vending controller.
package machine_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        REFUND  = 2'd3
    } state_e;

    localparam int unsigned NICKEL_C  = 5;
    localparam int unsigned DIME_C    = 10;
    localparam int unsigned QUARTER_C = 25;
    localparam int unsigned DOLLAR_C  = 100;

endpackage

// File: rtl/machine_edge_det.sv
// Two-stage sampler with rising-edge detect for the front-panel strobes.
module machine_edge_det (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] in,
    output logic [4:0] rise
);

    logic [4:0] smp_q;
    logic [4:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q  <= '0;
            prev_q <= '0;
        end else begin
            smp_q  <= in;
            prev_q <= smp_q;
        end
    end

    assign rise = smp_q & ~prev_q;

endmodule

// File: rtl/machine.sv
// Vending controller: credit accumulation, vend and refund FSM.
// Define MACHINE_VEND_COUNT_EN to add the vend_count output.
module machine
    import machine_pkg::*;
#(
    parameter int unsigned PRICE    = 75,
    parameter int unsigned CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                N,
    input  logic                D,
    input  logic                Q,
    input  logic                O,
    input  logic                E,
    output logic                status,
    output logic                S,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] change,
`ifdef MACHINE_VEND_COUNT_EN
    output logic                change_vld,
    output logic [15:0]         vend_count
`else
    output logic                change_vld
`endif
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    logic [4:0]          rise;
    logic [CREDIT_W-1:0] coin_v;
    logic [CREDIT_W-1:0] sum;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                s_q, s_d;
    logic                vld_q, vld_d;
    logic                status_q;

    machine_edge_det u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .in    ({E, O, Q, D, N}),
        .rise  (rise)
    );

    always_comb begin
        coin_v = '0;
        if (rise[0]) coin_v = coin_v + CREDIT_W'(NICKEL_C);
        if (rise[1]) coin_v = coin_v + CREDIT_W'(DIME_C);
        if (rise[2]) coin_v = coin_v + CREDIT_W'(QUARTER_C);
        if (rise[3]) coin_v = coin_v + CREDIT_W'(DOLLAR_C);
    end

    assign sum = credit_q + coin_v;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = change_q;
        s_d      = 1'b0;
        vld_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (coin_v != '0) begin
                    state_d  = COLLECT;
                    credit_d = coin_v;
                end
            end
            COLLECT: begin
                credit_d = sum;
                // Coins land before the vend/refund decision.
                if (sum >= PRICE_C) begin
                    state_d  = VEND;
                    s_d      = 1'b1;
                    vld_d    = 1'b1;
                    change_d = sum - PRICE_C;
                end else if (rise[4]) begin
                    state_d  = REFUND;
                    vld_d    = 1'b1;
                    change_d = sum;
                end
            end
            VEND, REFUND: begin
                credit_d = coin_v;
                state_d  = (coin_v != '0) ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            credit_q <= '0;
            change_q <= '0;
            s_q      <= 1'b0;
            vld_q    <= 1'b0;
            status_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            s_q      <= s_d;
            vld_q    <= vld_d;
            status_q <= (credit_d != '0);
        end
    end

`ifdef MACHINE_VEND_COUNT_EN
    logic [15:0] vcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcnt_q <= '0;
        end else if (s_d) begin
            vcnt_q <= vcnt_q + 16'd1;
        end
    end

    assign vend_count = vcnt_q;
`endif

    assign status     = status_q;
    assign S          = s_q;
    assign credit     = credit_q;
    assign change     = change_q;
    assign change_vld = vld_q;

endmodule

// File: tb/tb_machine.sv
// Self-checking bench for machine: directed scenarios plus random strobes vs a cents model.
module tb_machine;

    localparam int P = 75;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       N, D, Q, O, E;
    logic       status, S, change_vld;
    logic [7:0] credit, change;
`ifdef MACHINE_VEND_COUNT_EN
    logic [15:0] vend_count;
`endif

    machine #(.PRICE(P), .CREDIT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .N          (N),
        .D          (D),
        .Q          (Q),
        .O          (O),
        .E          (E),
        .status     (status),
        .S          (S),
        .credit     (credit),
        .change     (change),
`ifdef MACHINE_VEND_COUNT_EN
        .change_vld (change_vld),
        .vend_count (vend_count)
`else
        .change_vld (change_vld)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    localparam logic [4:0] MN = 5'b00001;
    localparam logic [4:0] MD = 5'b00010;
    localparam logic [4:0] MQ = 5'b00100;
    localparam logic [4:0] MO = 5'b01000;
    localparam logic [4:0] ME = 5'b10000;

    // Reference: credit in cents; "paid" marks the cycle right after a payout.
    logic [4:0] h1, h2;
    int  m_credit, m_chg, m_vc;
    bit  m_paid, m_s, m_vld;
    int  n_s, last_chg;

    task automatic model_reset();
        h1 = '0; h2 = '0;
        m_credit = 0; m_chg = 0; m_vc = 0;
        m_paid = 0; m_s = 0; m_vld = 0;
    endtask

    task automatic model_edge(input logic [4:0] cur);
        logic [4:0] r;
        int cv, nc;
        r  = h1 & ~h2;
        cv = 5 * r[0] + 10 * r[1] + 25 * r[2] + 100 * r[3];
        m_s = 0;
        m_vld = 0;
        if (m_paid) begin
            m_credit = cv;
            m_paid = 0;
        end else if (m_credit == 0) begin
            m_credit = cv;
        end else begin
            nc = m_credit + cv;
            m_credit = nc;
            if (nc >= P) begin
                m_s = 1; m_vld = 1; m_chg = nc - P; m_paid = 1;
                m_vc = (m_vc + 1) % 65536;
            end else if (r[4]) begin
                m_vld = 1; m_chg = nc; m_paid = 1;
            end
        end
        h2 = h1;
        h1 = cur;
    endtask

    task automatic drive(input logic [4:0] v);
        {E, O, Q, D, N} = v;
    endtask

    // One clock: drive at negedge, model at posedge, check at next negedge.
    task automatic cyc(input logic [4:0] v);
        drive(v);
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
        check("credit", credit, m_credit);
        check("status", status, (m_credit != 0));
        check("S", S, m_s);
        check("change_vld", change_vld, m_vld);
        check("change", change, m_chg);
`ifdef MACHINE_VEND_COUNT_EN
        check("vend_count", vend_count, m_vc);
`endif
        if (S) n_s++;
        if (change_vld) last_chg = change;
    endtask

    task automatic hold(input logic [4:0] v, input int n);
        repeat (n) cyc(v);
        repeat (2) cyc('0);
    endtask

    initial begin
        drive('0);
        rst_n = 1'b0;
        model_reset();
        #12;
        check("rst_credit", credit, 0);
        check("rst_status", status, 0);
        check("rst_S", S, 0);
        check("rst_vld", change_vld, 0);
        check("rst_change", change, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Q,D,Q,D,N reaching exactly 75
        n_s = 0; last_chg = -1;
        hold(MQ, 3); hold(MD, 3); hold(MQ, 3); hold(MD, 3); hold(MN, 3);
        check("t1_vends", n_s, 1);
        check("t1_change", last_chg, 0);
        check("t1_credit", credit, 0);

        // Dollar alone overpays by 25
        n_s = 0; last_chg = -1;
        hold(MO, 2); cyc('0);
        check("t2_vends", n_s, 1);
        check("t2_change", last_chg, 25);
        check("t2_status", status, 0);

        // Q,D then eject
        n_s = 0; last_chg = -1;
        hold(MQ, 2); hold(MD, 2); hold(ME, 2);
        check("t3_vends", n_s, 0);
        check("t3_change", last_chg, 35);
        check("t3_credit", credit, 0);

        // Held quarter counts once, then eject it back
        hold(MQ, 10);
        check("t4_credit", credit, 25);
        last_chg = -1;
        hold(ME, 2);
        check("t4_refund", last_chg, 25);

        // Simultaneous N,D,Q then Q+E together
        hold(MN | MD | MQ, 2);
        check("t5_credit", credit, 40);
        last_chg = -1; n_s = 0;
        hold(MQ | ME, 2);
        check("t5_refund", last_chg, 65);
        check("t5_vends", n_s, 0);

        // Eject in idle is ignored
        last_chg = -1;
        hold(ME, 2);
        check("idle_eject", last_chg, -1);

        // Async reset mid-collect
        hold(MQ, 2); hold(MQ, 2);
        check("t6_credit_pre", credit, 50);
        #2 rst_n = 1'b0;
        #1;
        check("t6_credit", credit, 0);
        check("t6_status", status, 0);
        check("t6_S", S, 0);
        check("t6_vld", change_vld, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MACHINE_VEND_COUNT_EN
        repeat (3) begin
            hold(MO, 2);
            cyc('0);
        end
        check("vcount3", vend_count, 3);
`endif

        // Random strobes, sometimes held
        for (int i = 0; i < 400; i++) begin
            logic [4:0] v;
            v = 5'($urandom) & 5'($urandom);
            if (v[4] && ($urandom_range(0, 3) != 0)) v[4] = 1'b0;
            repeat ($urandom_range(1, 3)) cyc(v);
        end
        repeat (4) cyc('0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
